// File: rtl/x2p_apb_pkg.sv
// Shared types and defaults for the X2P bridge APB master side.
package x2p_apb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } state_e;

   typedef enum logic [1:0] {
      RspOkay    = 2'b00,
      RspSlverr  = 2'b01,
      RspDecerr  = 2'b10,
      RspTimeout = 2'b11
   } rsp_code_e;

   localparam int unsigned DefSlvAw = 12;
   localparam int unsigned DefIdxW  = 4;

endpackage

// File: rtl/x2p_apb_timeout.sv
// Loadable ACCESS-phase cycle counter; expired never asserts when TIMEOUT is 0.
module x2p_apb_timeout #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          expired
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/x2p_apb_master_ctrl.sv
// APB master sequencer: one command at a time, address decode, SETUP/ACCESS, single response.
module x2p_apb_master_ctrl
   import x2p_apb_pkg::*;
#(
   parameter int unsigned SLAVE_NUM = 3,
   parameter int unsigned SLV_AW    = DefSlvAw,
   parameter int unsigned IDX_W     = DefIdxW,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                      pclk,
   input  logic                      preset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [31:0]               cmd_addr,
   input  logic                      cmd_write,
   input  logic [31:0]               cmd_wdata,
   input  logic [3:0]                cmd_strb,
   input  logic [2:0]                cmd_prot,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_err,
   output logic [1:0]                rsp_code,
   output logic [SLAVE_NUM:0]        psel,
   output logic                      penable,
   output logic [31:0]               paddr,
   output logic                      pwrite,
   output logic [31:0]               pwdata,
   output logic [3:0]                pstrb,
   output logic [2:0]                pprot,
   input  logic [SLAVE_NUM:0]        pready,
   input  logic [SLAVE_NUM:0][31:0]  prdata,
   input  logic [SLAVE_NUM:0]        pslverr
);

   localparam int unsigned NS = SLAVE_NUM + 1;
   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   state_e          state_q;
   rsp_code_e       rsp_code_q;
   logic [IDX_W-1:0] idx_dec;
   logic [NS-1:0]   sel_dec;
   logic            dec_err;
   logic            sel_ready;
   logic            sel_err;
   logic [31:0]     sel_rdata;
   logic            tmo_expired;

   assign idx_dec = cmd_addr[SLV_AW +: IDX_W];
   assign dec_err = 32'(idx_dec) > SLAVE_NUM;
   assign sel_dec = NS'(1) << idx_dec;

   // psel is one-hot, so masking with it selects the active slave's return signals.
   assign sel_ready = |(pready & psel);
   assign sel_err   = |(pslverr & psel);

   always_comb begin
      sel_rdata = '0;
      for (int unsigned i = 0; i < NS; i++) begin
         if (psel[i]) sel_rdata = sel_rdata | prdata[i];
      end
   end

   x2p_apb_timeout #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_timeout (
      .clk      (pclk),
      .rst_n    (preset_n),
      .clr      ((state_q != StSetup) && (state_q != StAccess)),
      .load     (state_q == StSetup),
      .load_val (CW'(1)),
      .en       (state_q == StAccess),
      .expired  (tmo_expired)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q    <= StIdle;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         rsp_code_q <= RspOkay;
         psel       <= '0;
         penable    <= 1'b0;
         paddr      <= '0;
         pwrite     <= 1'b0;
         pwdata     <= '0;
         pstrb      <= '0;
         pprot      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (dec_err) begin
                     state_q    <= StResp;
                     rsp_valid  <= 1'b1;
                     rsp_rdata  <= '0;
                     rsp_err    <= 1'b1;
                     rsp_code_q <= RspDecerr;
                  end else begin
                     state_q <= StSetup;
                     psel    <= sel_dec;
                     paddr   <= cmd_addr;
                     pwrite  <= cmd_write;
                     pwdata  <= cmd_wdata;
                     pstrb   <= cmd_write ? cmd_strb : 4'b0000;
                     pprot   <= cmd_prot;
                  end
               end
            end
            StSetup: begin
               state_q <= StAccess;
               penable <= 1'b1;
            end
            StAccess: begin
               // A ready in the same cycle the counter expires still completes normally.
               if (sel_ready) begin
                  state_q    <= StResp;
                  psel       <= '0;
                  penable    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= (pwrite || sel_err) ? 32'h0 : sel_rdata;
                  rsp_err    <= sel_err;
                  rsp_code_q <= sel_err ? RspSlverr : RspOkay;
               end else if (tmo_expired) begin
                  state_q    <= StResp;
                  psel       <= '0;
                  penable    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= '0;
                  rsp_err    <= 1'b1;
                  rsp_code_q <= RspTimeout;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state_q   <= StIdle;
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rsp_code = rsp_code_q;

endmodule

// File: doc/x2p_apb_master_ctrl.md
Name: x2p_apb_master_ctrl

Overview:
- APB master-side sequencer for the X2P bridge.
- Accepts one command at a time from the AXI-side front end and decodes the address to one of SLAVE_NUM+1 APB slaves.
- Drives the APB SETUP/ACCESS protocol, muxes pready/prdata/pslverr back from the selected slave, and returns a single response.
- Adds decode-error and wait-state timeout handling, so a missing or hung slave can never stall the AXI side.

Parameters:
- SLAVE_NUM, 3, highest slave index; APB select/ready/error vectors are SLAVE_NUM+1 bits wide.
- SLV_AW, 12, log2 of bytes per slave window; slave index = paddr[SLV_AW +: IDX_W].
- IDX_W, 4, width of the decoded slave-index field.
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; single clock domain.
- preset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_addr  in  32  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, decode error or timeout.
- rsp_code  out  2  00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT.
- psel  out  SLAVE_NUM+1  one-hot slave select.
- penable  out  1  APB enable.
- paddr  out  32  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB strobes.
- pprot  out  3  APB protection.
- pready  in  SLAVE_NUM+1  per-slave ready.
- prdata  in  [SLAVE_NUM:0][31:0]  per-slave read data.
- pslverr  in  SLAVE_NUM+1  per-slave error.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0 except cmd_ready=1; state=IDLE; timeout counter=0.
- Asserting preset_n low mid-transfer clears everything immediately, including psel and penable. The in-flight command is lost and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr/write/wdata/strb/prot and compute idx.
  - If idx > SLAVE_NUM: go to RESP with code=DECERR, rdata=0. No psel is ever asserted.
  - Otherwise: go to SETUP.
- SETUP (exactly 1 cycle):
  - psel[idx]=1, penable=0.
  - paddr/pwrite/pwdata/pprot driven from latched values.
  - pstrb = cmd_strb for writes, 4'b0 for reads.
  - Next state: ACCESS.
- ACCESS:
  - penable=1; psel, paddr and all controls held stable.
  - Count cycles.
  - When pready[idx]=1: capture prdata[idx] (reads only, else 0) and pslverr[idx] (code=SLVERR if set, else OKAY). Deassert psel/penable on the next edge and go to RESP.
  - pready/pslverr of non-selected slaves are ignored.
  - If TIMEOUT≠0 and the count reaches TIMEOUT with no pready: deassert psel/penable, code=TIMEOUT, rdata=0, go to RESP.
  - If pready arrives on the same cycle the count reaches TIMEOUT, pready wins and the response is a normal completion.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err/rsp_code held stable until rsp_ready.
  - On rsp_ready: go to IDLE.
  - cmd_ready=0 in every non-IDLE state.
- Latency: a zero-wait-state slave completes in 3 cycles from command accept to rsp_valid (accept, SETUP, ACCESS). Each pready=0 cycle adds 1.
- Throughput: at most one transfer per 4 cycles. psel and penable are never high for more than one slave.
- Address fields paddr[1:0] are passed through unmodified; no alignment checking.

Decomposition:
- Package x2p_apb_pkg holds:
  - state enum: IDLE, SETUP, ACCESS, RESP.
  - rsp_code enum: OKAY, SLVERR, DECERR, TIMEOUT.
  - default constants for SLV_AW and IDX_W.
- Sub-module x2p_apb_timeout: loadable cycle counter with clear/enable inputs and an expired flag. TIMEOUT=0 keeps expired permanently low.
- Decode and the ready/data mux stay inline.

Test Plan:
- Read to slave 2 at addr 0x0000_2010 with pready high at the first ACCESS cycle and prdata[2]=0xA5A5_0001:
  - psel=4'b0100 for 2 cycles; penable high only in the 2nd.
  - rsp_rdata=0xA5A5_0001, code=00, rsp_valid 3 cycles after accept.
- Write to slave 1 at 0x1004, wdata=0xDEAD_BEEF, strb=4'b0011, with pready delayed 3 cycles:
  - paddr/pwdata/pstrb stable across all 4 ACCESS cycles.
  - rsp_err=0, rsp_rdata=0.
- Read to 0x0000_5000 (idx 5 > 3):
  - psel stays 0.
  - rsp_code=10, rsp_err=1, rsp_rdata=0.
- Slave 0 holds pready=0 with TIMEOUT=16:
  - psel drops after 16 ACCESS cycles.
  - rsp_code=11.
  - The next command proceeds normally.
- Slave 3 returns pslverr=1 with pready; slave 2 simultaneously drives pslverr=1 and pready=1:
  - rsp_code=01, taken from slave 3 only.
  - A repeat transfer to slave 2 with its pslverr=0 returns code=00 (non-selected slaves' signals ignored).
- preset_n pulsed low during ACCESS:
  - psel/penable drop asynchronously; rsp_valid=0; cmd_ready=1 after release.
  - No response is issued for the aborted command.
